cq_viola_nios2_e_jtag_scan_master: RTL and testbench

Scan master that drives the CPU's JTAG debug module from on-chip logic instead of the device TAP. It generates the virtual-JTAG handshake that the debug module's TCK side consumes:
- `vji_tck`
- `vji_ir_in`
- the UIR/CDR/SDR/UDR/RTI state strobes
- `vji_tdi`

It also collects `vji_tdo`. One command performs one IR update plus one full DR scan. It is used by the self-test sequencer and by simulation benches to issue OCI memory, break, trace-memory and trace-control transactions.

---
 rtl/cq_viola_nios2_e_jtag_scan_pkg.sv | 34 +++
 rtl/cq_viola_nios2_e_jtag_scan_master_if.sv | 55 +++++
 rtl/cq_viola_nios2_e_jtag_tck_gen.sv | 48 ++++
 rtl/cq_viola_nios2_e_jtag_scan_master.sv | 195 +++++++++++++++++++
 tb/tb_cq_viola_nios2_e_jtag_scan_master.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cq_viola_nios2_e_jtag_scan_pkg.sv
`default_nettype none
//==============================================================================
// Module   : cq_viola_nios2_e_jtag_scan_pkg
// Brief    : Shared types and constants for the JTAG debug-module scan master:
//            scan state encoding, virtual IR codes and default widths.
// Revision : 1.0 - initial release
//==============================================================================
package cq_viola_nios2_e_jtag_scan_pkg;

    // Default geometry of the debug module scan chain and TCK pacing.
    localparam int c_DEFAULT_DR_WIDTH   = 38;
    localparam int c_DEFAULT_IR_WIDTH   = 2;
    localparam int c_DEFAULT_TCK_DIV    = 2;
    localparam int c_DEFAULT_RTI_CYCLES = 2;

    // Virtual IR codes understood by the debug module.
    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    // One state per virtual TAP phase, plus idle and response hold.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5,
        ST_RESP = 3'd6
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/cq_viola_nios2_e_jtag_scan_master_if.sv
`default_nettype none
//==============================================================================
// Module   : cq_viola_nios2_e_jtag_scan_master_if
// Brief    : Command/response handshake and virtual-JTAG pins of the scan
//            master. The slave modport is the scan master itself; the master
//            modport is the requester together with the debug module side.
// Revision : 1.0 - initial release
//==============================================================================
interface cq_viola_nios2_e_jtag_scan_master_if
    import cq_viola_nios2_e_jtag_scan_pkg::*;
#(
    parameter int DR_WIDTH = c_DEFAULT_DR_WIDTH,
    parameter int IR_WIDTH = c_DEFAULT_IR_WIDTH
);

    // Command channel
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_data;

    // Response channel
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_data;
    logic [IR_WIDTH-1:0] rsp_ir_out;

    // Virtual JTAG towards the debug module
    logic                vji_tck;
    logic                vji_tdi;
    logic                vji_tdo;
    logic [IR_WIDTH-1:0] vji_ir_in;
    logic [IR_WIDTH-1:0] vji_ir_out;
    logic                vji_uir;
    logic                vji_cdr;
    logic                vji_sdr;
    logic                vji_udr;
    logic                vji_rti;

    modport slave (
        input  cmd_valid, cmd_ir, cmd_data, rsp_ready, vji_tdo, vji_ir_out,
        output cmd_ready, rsp_valid, rsp_data, rsp_ir_out,
        output vji_tck, vji_tdi, vji_ir_in,
        output vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );

    modport master (
        output cmd_valid, cmd_ir, cmd_data, rsp_ready, vji_tdo, vji_ir_out,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out,
        input  vji_tck, vji_tdi, vji_ir_in,
        input  vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );

endinterface
`default_nettype wire

// File: rtl/cq_viola_nios2_e_jtag_tck_gen.sv
`default_nettype none
//==============================================================================
// Module   : cq_viola_nios2_e_jtag_tck_gen
// Brief    : Divides clk into a TCK of TCK_DIV clk cycles per half-period.
//            tck_rise/tck_fall are single-clk enables asserted in the cycle
//            whose closing clk edge makes TCK rise/fall, so logic that acts on
//            them changes state together with TCK.
// Revision : 1.0 - initial release
//==============================================================================
module cq_viola_nios2_e_jtag_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  wire  clk,
    input  wire  reset_n,
    input  wire  run,
    output logic tck,
    output logic tck_rise,
    output logic tck_fall
);

    localparam int                 c_CNT_W    = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TCK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_half_cnt;
    logic               r_tck;
    logic               w_half_end;

    assign w_half_end = run && (r_half_cnt == c_CNT_LAST);
    assign tck_rise   = w_half_end && !r_tck;
    assign tck_fall   = w_half_end && r_tck;
    assign tck        = r_tck;

    // Half-period counter; TCK toggles on each wrap and parks low while stopped.
    always_ff @(posedge clk) begin
        if (!reset_n || !run) begin
            r_half_cnt <= '0;
            r_tck      <= 1'b0;
        end else if (w_half_end) begin
            r_half_cnt <= '0;
            r_tck      <= !r_tck;
        end else begin
            r_half_cnt <= r_half_cnt + c_CNT_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cq_viola_nios2_e_jtag_scan_master.sv
`default_nettype none
//==============================================================================
// Module   : cq_viola_nios2_e_jtag_scan_master
// Brief    : Drives the CPU debug module's virtual-JTAG TCK side from on-chip
//            logic. Each command does one IR update followed by one full DR
//            scan (UIR, CDR, SDR, UDR, RTI) and returns the captured TDO bits.
// Revision : 1.0 - initial release
//==============================================================================
module cq_viola_nios2_e_jtag_scan_master
    import cq_viola_nios2_e_jtag_scan_pkg::*;
#(
    parameter int DR_WIDTH   = c_DEFAULT_DR_WIDTH,
    parameter int IR_WIDTH   = c_DEFAULT_IR_WIDTH,
    parameter int TCK_DIV    = c_DEFAULT_TCK_DIV,
    parameter int RTI_CYCLES = c_DEFAULT_RTI_CYCLES
) (
    input  wire clk,
    input  wire reset_n,
    cq_viola_nios2_e_jtag_scan_master_if.slave bus
);

    // Bit counter must reach DR_WIDTH to mark the end of the shift phase.
    localparam int                 c_BIT_W    = $clog2(DR_WIDTH + 1);
    localparam int                 c_IDX_W    = $clog2(DR_WIDTH);
    localparam int                 c_PER_W    = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DR_WIDTH);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);
    localparam logic [c_PER_W-1:0] c_PER_LAST = c_PER_W'(RTI_CYCLES - 1);
    localparam logic [c_PER_W-1:0] c_PER_ONE  = c_PER_W'(1);

    scan_state_t         r_state;
    scan_state_t         w_state_next;

    logic [IR_WIDTH-1:0] r_ir_q;
    logic [DR_WIDTH-1:0] r_dr_q;
    logic [c_BIT_W-1:0]  r_bitcnt;
    logic [c_PER_W-1:0]  r_period_cnt;
    logic                r_tdi;
    logic                r_uir;
    logic                r_cdr;
    logic                r_sdr;
    logic                r_udr;
    logic                r_rti;
    logic                r_rsp_valid;
    logic                r_rsp_pending;
    logic [DR_WIDTH-1:0] r_rsp_data;
    logic [IR_WIDTH-1:0] r_rsp_ir_out;

    logic                w_run;
    logic                w_tck;
    logic                w_tck_rise;
    logic                w_tck_fall;
    logic                w_cmd_ready;
    logic                w_accept;
    logic                w_sdr_done;
    logic                w_rti_done;
    logic [c_IDX_W-1:0]  w_bit_idx;
    logic                w_tdi_next;

    // TCK only runs while a scan phase is active.
    assign w_run = (r_state != ST_IDLE) && (r_state != ST_RESP);

    cq_viola_nios2_e_jtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (w_run),
        .tck      (w_tck),
        .tck_rise (w_tck_rise),
        .tck_fall (w_tck_fall)
    );

    // The first IDLE cycle after a response is held off so that a new command
    // can never be accepted in the same cycle the response is retired.
    assign w_cmd_ready = (r_state == ST_IDLE) && !r_rsp_pending;
    assign w_accept    = bus.cmd_valid && w_cmd_ready;
    assign w_sdr_done  = (r_bitcnt == c_BIT_LAST);
    assign w_rti_done  = (r_period_cnt == c_PER_LAST);
    assign w_bit_idx   = r_bitcnt[c_IDX_W-1:0];

    // Scan phase sequencing; every phase ends on a TCK falling edge.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)                 w_state_next = ST_UIR;
            ST_UIR:  if (w_tck_fall)               w_state_next = ST_CDR;
            ST_CDR:  if (w_tck_fall)               w_state_next = ST_SDR;
            ST_SDR:  if (w_tck_fall && w_sdr_done) w_state_next = ST_UDR;
            ST_UDR:  if (w_tck_fall)               w_state_next = ST_RTI;
            ST_RTI:  if (w_tck_fall && w_rti_done) w_state_next = ST_RESP;
            ST_RESP: if (bus.rsp_ready)            w_state_next = ST_IDLE;
            default:                               w_state_next = ST_IDLE;
        endcase
    end

    // TDI presents the next DR bit after each falling edge while shifting.
    always_comb begin
        w_tdi_next = 1'b0;
        if ((w_state_next == ST_SDR) && !w_sdr_done) begin
            w_tdi_next = r_dr_q[w_bit_idx];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Command capture, bit/period counters and TDI.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ir_q       <= '0;
            r_dr_q       <= '0;
            r_bitcnt     <= '0;
            r_period_cnt <= '0;
            r_tdi        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ir_q       <= bus.cmd_ir;
                r_dr_q       <= bus.cmd_data;
                r_bitcnt     <= '0;
                r_period_cnt <= '0;
            end
            if ((r_state == ST_SDR) && w_tck_rise) begin
                r_bitcnt <= r_bitcnt + c_BIT_ONE;
            end
            if ((r_state == ST_RTI) && w_tck_fall) begin
                r_period_cnt <= w_rti_done ? '0 : (r_period_cnt + c_PER_ONE);
            end
            if (w_tck_fall) begin
                r_tdi <= w_tdi_next;
            end
        end
    end

    // Phase strobes are registered copies of the upcoming state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_uir <= 1'b0;
            r_cdr <= 1'b0;
            r_sdr <= 1'b0;
            r_udr <= 1'b0;
            r_rti <= 1'b0;
        end else begin
            r_uir <= (w_state_next == ST_UIR);
            r_cdr <= (w_state_next == ST_CDR);
            r_sdr <= (w_state_next == ST_SDR);
            r_udr <= (w_state_next == ST_UDR);
            r_rti <= (w_state_next == ST_RTI);
        end
    end

    // TDO capture, IR status capture and response handshake.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rsp_data    <= '0;
            r_rsp_ir_out  <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_pending <= 1'b0;
        end else begin
            if ((r_state == ST_SDR) && w_tck_rise) begin
                r_rsp_data[w_bit_idx] <= bus.vji_tdo;
            end
            if ((r_state == ST_UDR) && w_tck_rise) begin
                r_rsp_ir_out <= bus.vji_ir_out;
            end
            r_rsp_valid <= (w_state_next == ST_RESP);
            if (w_state_next == ST_RESP) begin
                r_rsp_pending <= 1'b1;
            end else if (r_state == ST_IDLE) begin
                r_rsp_pending <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_ir_out = r_rsp_ir_out;
    assign bus.vji_tck    = w_tck;
    assign bus.vji_tdi    = r_tdi;
    assign bus.vji_ir_in  = r_ir_q;
    assign bus.vji_uir    = r_uir;
    assign bus.vji_cdr    = r_cdr;
    assign bus.vji_sdr    = r_sdr;
    assign bus.vji_udr    = r_udr;
    assign bus.vji_rti    = r_rti;

endmodule
`default_nettype wire

// File: tb/tb_cq_viola_nios2_e_jtag_scan_master.sv
`default_nettype none
//==============================================================================
// Module   : tb_cq_viola_nios2_e_jtag_scan_master
// Brief    : Directed self-checking bench for the JTAG scan master with a
//            shift-register model of the debug module DR on the TCK side.
// Revision : 1.0 - initial release
//==============================================================================
module tb_cq_viola_nios2_e_jtag_scan_master;
    import cq_viola_nios2_e_jtag_scan_pkg::*;

    localparam int c_DRW = 38;
    localparam int c_IRW = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int acc_cnt  = 0;
    int acc_last = 0;
    int acc_prev = 0;
    int n_uir    = 0;
    int n_cdr    = 0;
    int n_sdr    = 0;
    int n_udr    = 0;
    int n_rti    = 0;
    int excl_bad = 0;

    logic             model_load = 1'b0;
    logic [c_DRW-1:0] model_init = '0;
    logic [c_DRW-1:0] model;
    logic [c_IRW-1:0] ir_out_val = '0;

    cq_viola_nios2_e_jtag_scan_master_if #(.DR_WIDTH(c_DRW), .IR_WIDTH(c_IRW)) bus ();

    cq_viola_nios2_e_jtag_scan_master #(
        .DR_WIDTH   (c_DRW),
        .IR_WIDTH   (c_IRW),
        .TCK_DIV    (2),
        .RTI_CYCLES (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Debug module DR model: shifts in SDR, TDI into MSB, TDO from LSB.
    always @(posedge bus.vji_tck or posedge model_load) begin
        if (model_load)       model <= model_init;
        else if (bus.vji_sdr) model <= {bus.vji_tdi, model[c_DRW-1:1]};
    end
    assign bus.vji_tdo    = model[0];
    assign bus.vji_ir_out = bus.vji_udr ? ir_out_val : '0;

    // TCK rising edges seen under each strobe.
    always @(posedge bus.vji_tck) begin
        if (bus.vji_uir) n_uir <= n_uir + 1;
        if (bus.vji_cdr) n_cdr <= n_cdr + 1;
        if (bus.vji_sdr) n_sdr <= n_sdr + 1;
        if (bus.vji_udr) n_udr <= n_udr + 1;
        if (bus.vji_rti) n_rti <= n_rti + 1;
    end

    // Strobes must be mutually exclusive.
    always @(negedge clk) begin
        if ($countones({bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti}) > 1)
            excl_bad <= excl_bad + 1;
    end

    // Cycle counter and command acceptance log.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.cmd_valid && bus.cmd_ready) begin
            acc_prev <= acc_last;
            acc_last <= cyc;
            acc_cnt  <= acc_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int lat;
        int base;
        int guard;
        int rsp_seen;
        int bad_ir;
        int spurious;

        bus.cmd_valid = 1'b0;
        bus.cmd_ir    = '0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_tck", bus.vji_tck, 0);
        check("rst_strobes", {bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti}, 0);
        check("rst_tdi", bus.vji_tdi, 0);
        check("rst_ir_in", bus.vji_ir_in, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_ir_out", bus.rsp_ir_out, 0);

        // Loopback scan, IR status and strobe sequencing
        model_init = 38'h15_0F0F_F0F0;
        model_load = 1'b1;
        #1 model_load = 1'b0;
        ir_out_val    = 2'b11;
        bus.cmd_valid = 1'b1;
        bus.cmd_ir    = IR_OCIMEM;
        bus.cmd_data  = 38'h2A_5A5A_5A5A;
        check("loop_ready_c0", bus.cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("loop_uir_c1", bus.vji_uir, 1);
        check("loop_tck_c1", bus.vji_tck, 0);
        check("loop_ir_in_c1", bus.vji_ir_in, IR_OCIMEM);
        check("loop_busy_c1", bus.cmd_ready, 0);
        lat = 1;
        while (!bus.rsp_valid && lat < 400) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("loop_latency", lat, 173);
        check("loop_rsp_data", bus.rsp_data, 38'h15_0F0F_F0F0);
        check("loop_model", model, 38'h2A_5A5A_5A5A);
        check("loop_rsp_ir_out", bus.rsp_ir_out, 2'b11);
        check("seq_uir", n_uir, 1);
        check("seq_cdr", n_cdr, 1);
        check("seq_sdr", n_sdr, 38);
        check("seq_udr", n_udr, 1);
        check("seq_rti", n_rti, 2);
        check("seq_exclusive", excl_bad, 0);

        // Backpressure with a queued command
        bus.cmd_valid = 1'b1;
        bus.cmd_ir    = IR_BREAK;
        bus.cmd_data  = 38'h3F_0000_FFFF;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_rsp_valid", bus.rsp_valid, 1);
            check("bp_rsp_data", bus.rsp_data, 38'h15_0F0F_F0F0);
            check("bp_cmd_ready", bus.cmd_ready, 0);
            check("bp_no_uir", bus.vji_uir, 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("bp_rsp_dropped", bus.rsp_valid, 0);
        check("bp_gap_ready", bus.cmd_ready, 0);
        check("bp_gap_uir", bus.vji_uir, 0);
        @(posedge clk);
        @(negedge clk);
        check("bp_ready_after", bus.cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("bp_queued_uir", bus.vji_uir, 1);
        check("bp_ir_in_break", bus.vji_ir_in, IR_BREAK);

        // Reset during the 10th SDR bit
        base  = n_sdr;
        guard = 0;
        while ((n_sdr - base) < 10 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("abort_reached", n_sdr - base, 10);
        check("abort_in_sdr", bus.vji_sdr, 1);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_tck", bus.vji_tck, 0);
        check("abort_strobes", {bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti}, 0);
        check("abort_tdi", bus.vji_tdi, 0);
        check("abort_ir_in", bus.vji_ir_in, 0);
        check("abort_rsp_valid", bus.rsp_valid, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_cmd_ready", bus.cmd_ready, 1);
        spurious = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.vji_uir) spurious++;
        end
        check("abort_no_rsp", spurious, 0);

        // Back-to-back commands with rsp_ready held high
        model_init = 38'h00_1234_5678;
        model_load = 1'b1;
        #1 model_load = 1'b0;
        ir_out_val    = 2'b01;
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_ir    = IR_TRACECTRL;
        bus.cmd_data  = 38'h3C_DEAD_BEEF;
        base = acc_cnt;
        @(posedge clk);
        @(negedge clk);
        check("b2b_first_acc", acc_cnt - base, 1);
        check("b2b_ir_in_a", bus.vji_ir_in, IR_TRACECTRL);
        bus.cmd_ir   = IR_TRACEMEM;
        bus.cmd_data = 38'h01_CAFE_F00D;
        bad_ir   = 0;
        rsp_seen = 0;
        guard    = 0;
        while ((acc_cnt - base) < 2 && guard < 400) begin
            if (bus.rsp_valid) begin
                rsp_seen++;
                check("b2b_rsp_data_a", bus.rsp_data, 38'h00_1234_5678);
                check("b2b_rsp_ir_a", bus.rsp_ir_out, 2'b01);
            end
            if (bus.vji_ir_in !== IR_TRACECTRL) bad_ir++;
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        bus.cmd_valid = 1'b0;
        check("b2b_second_acc", acc_cnt - base, 2);
        check("b2b_spacing", acc_last - acc_prev, 175);
        check("b2b_ir_in_hold", bad_ir, 0);
        check("b2b_rsp_a_seen", rsp_seen, 1);
        check("b2b_uir_b", bus.vji_uir, 1);
        check("b2b_ir_in_b", bus.vji_ir_in, IR_TRACEMEM);
        ir_out_val = 2'b10;
        lat = 1;
        while (!bus.rsp_valid && lat < 400) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("b2b_latency_b", lat, 173);
        check("b2b_rsp_data_b", bus.rsp_data, 38'h3C_DEAD_BEEF);
        check("b2b_model_b", model, 38'h01_CAFE_F00D);
        check("b2b_rsp_ir_b", bus.rsp_ir_out, 2'b10);
        check("b2b_exclusive", excl_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
